// File: rtl/aer_event_decoder.sv
// aer_event_decoder
// Receive side of the address-event link. It decodes each incoming packed AER
// word into {x, y, ts, pol} and range-checks the address. The wrapping raw
// timestamp is extended with an epoch counter. In-range events are buffered
// in a show-ahead FIFO and handed to the consumer over valid/ready. Malformed
// and dropped events are counted.
//
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   evt_valid_i      evt_data_i carries an event this cycle (no backpressure)
//   evt_data_i       {x, y, ts, pol} packed word
//   flush_i          synchronous FIFO clear; same-cycle event is discarded
//   out_valid_o      head event available
//   out_ready_i      consumer accepts the head event
//   out_x_o/out_y_o  head row/column address
//   out_ts_o         head extended timestamp {epoch, ts}
//   out_pol_o        head polarity
//   fifo_level_o     current FIFO occupancy
//   drop_cnt_o       saturating count of events lost to a full FIFO
//   err_cnt_o        saturating count of out-of-range events
//   overflow_o       sticky flag, set on the first drop
module aer_event_decoder #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int X_WIDTH     = 2,
  parameter int Y_WIDTH     = 2,
  parameter int TS_WIDTH    = 8,
  parameter int WIDTH       = X_WIDTH + Y_WIDTH + TS_WIDTH + 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int EPOCH_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          evt_valid_i,
  input  logic [WIDTH-1:0]              evt_data_i,
  input  logic                          flush_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [X_WIDTH-1:0]            out_x_o,
  output logic [Y_WIDTH-1:0]            out_y_o,
  output logic [EPOCH_WIDTH+TS_WIDTH-1:0] out_ts_o,
  output logic                          out_pol_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o,
  output logic [CNT_WIDTH-1:0]          err_cnt_o,
  output logic                          overflow_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int EXT_W   = EPOCH_WIDTH + TS_WIDTH;
  localparam int ENTRY_W = X_WIDTH + Y_WIDTH + EXT_W + 1;

  // Combinational decode of the incoming word.
  logic [X_WIDTH-1:0]     evt_x;
  logic [Y_WIDTH-1:0]     evt_y;
  logic [TS_WIDTH-1:0]    evt_ts;
  logic                   evt_pol;
  logic                   in_range;

  assign evt_x    = evt_data_i[WIDTH-1 -: X_WIDTH];
  assign evt_y    = evt_data_i[WIDTH-1-X_WIDTH -: Y_WIDTH];
  assign evt_ts   = evt_data_i[TS_WIDTH:1];
  assign evt_pol  = evt_data_i[0];
  assign in_range = (32'(evt_x) < ROWS) && (32'(evt_y) < COLS);

  // Timestamp unwrap state.
  logic [EPOCH_WIDTH-1:0] epoch;
  logic [EPOCH_WIDTH-1:0] epoch_nxt;
  logic [TS_WIDTH-1:0]    last_ts;

  // A strictly smaller raw timestamp means the time-to-digital counter
  // wrapped; equal timestamps are simultaneous events, not a wrap.
  assign epoch_nxt = (evt_ts < last_ts) ? epoch + EPOCH_WIDTH'(1) : epoch;

  // FIFO state.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop_inc;
  logic               err_inc;
  logic [ENTRY_W-1:0] head;

  assign full = (level == LVL_W'(FIFO_DEPTH));
  assign pop  = out_valid_o && out_ready_i;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  // Everything arriving during a flush is discarded without being counted.
  assign push     = evt_valid_i && !flush_i && in_range && (!full || pop);
  assign drop_inc = evt_valid_i && !flush_i && in_range && full && !pop;
  assign err_inc  = evt_valid_i && !flush_i && !in_range;

  // Unwrap tracks every word on the link, including ones that are rejected,
  // so later accepted events carry a coherent extended time.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      epoch   <= '0;
      last_ts <= '0;
    end else if (evt_valid_i) begin
      epoch   <= epoch_nxt;
      last_ts <= evt_ts;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {evt_x, evt_y, epoch_nxt, evt_ts, evt_pol};
    end
  end

  // Pointer and level bookkeeping; flush wins over any push or pop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // Saturating event counters and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_o <= '0;
      err_cnt_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (drop_inc && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
      if (err_inc && (err_cnt_o != '1))   err_cnt_o  <= err_cnt_o + CNT_WIDTH'(1);
      if (drop_inc)                       overflow_o <= 1'b1;
    end
  end

  // Show-ahead output: the head entry is visible directly, zeroed when empty.
  assign out_valid_o  = (level != '0);
  assign head         = out_valid_o ? mem[rd_ptr] : '0;
  assign {out_x_o, out_y_o, out_ts_o, out_pol_o} = head;
  assign fifo_level_o = level;

endmodule

// File: tb/tb_aer_event_decoder.sv
// tb_aer_event_decoder
// Directed, table-driven bench for aer_event_decoder (ROWS=3 so that x=3 is
// out of range). Each table row gives the inputs for one clock cycle and the
// outputs expected just after the following rising edge. A hand-written
// sequence covers the asynchronous reset in the middle of a drain.
module tb_aer_event_decoder;

  localparam int ROWS = 3;
  localparam int COLS = 4;

  logic        clk_i;
  logic        reset_i;
  logic        evt_valid_i;
  logic [12:0] evt_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  out_x_o;
  logic [1:0]  out_y_o;
  logic [15:0] out_ts_o;
  logic        out_pol_o;
  logic [2:0]  fifo_level_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] err_cnt_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  aer_event_decoder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .evt_valid_i  (evt_valid_i),
    .evt_data_i   (evt_data_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_x_o      (out_x_o),
    .out_y_o      (out_y_o),
    .out_ts_o     (out_ts_o),
    .out_pol_o    (out_pol_o),
    .fifo_level_o (fifo_level_o),
    .drop_cnt_o   (drop_cnt_o),
    .err_cnt_o    (err_cnt_o),
    .overflow_o   (overflow_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        valid;
    logic [12:0] data;
    logic        flush;
    logic        ready;
    logic        e_valid;
    logic [1:0]  e_x;
    logic [1:0]  e_y;
    logic [15:0] e_ts;
    logic        e_pol;
    logic [2:0]  e_level;
    logic [15:0] e_drop;
    logic [15:0] e_err;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] w(input int x, input int y, input int ts, input int pol);
    return {2'(x), 2'(y), 8'(ts), 1'(pol)};
  endfunction

  function automatic vec_t mk_vec(input int valid, input logic [12:0] data, input int flush,
                                  input int ready, input int ev, input int ex, input int ey,
                                  input int ets, input int epol, input int elvl,
                                  input int edrop, input int eerr, input int eovf);
    vec_t v;
    v.valid   = 1'(valid);
    v.data    = data;
    v.flush   = 1'(flush);
    v.ready   = 1'(ready);
    v.e_valid = 1'(ev);
    v.e_x     = 2'(ex);
    v.e_y     = 2'(ey);
    v.e_ts    = 16'(ets);
    v.e_pol   = 1'(epol);
    v.e_level = 3'(elvl);
    v.e_drop  = 16'(edrop);
    v.e_err   = 16'(eerr);
    v.e_ovf   = 1'(eovf);
    return v;
  endfunction

  // Shorthand: valid, data, flush, ready, then expected
  // out_valid, x, y, ts, pol, level, drop, err, overflow.
  task automatic add_vec(input int valid, input logic [12:0] data, input int flush,
                         input int ready, input int ev, input int ex, input int ey,
                         input int ets, input int epol, input int elvl,
                         input int edrop, input int eerr, input int eovf);
    vecs.push_back(mk_vec(valid, data, flush, ready, ev, ex, ey, ets, epol,
                          elvl, edrop, eerr, eovf));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(out_valid_o),  32'(v.e_valid));
    check({tag, ".x"},     32'(out_x_o),      32'(v.e_x));
    check({tag, ".y"},     32'(out_y_o),      32'(v.e_y));
    check({tag, ".ts"},    32'(out_ts_o),     32'(v.e_ts));
    check({tag, ".pol"},   32'(out_pol_o),    32'(v.e_pol));
    check({tag, ".level"}, 32'(fifo_level_o), 32'(v.e_level));
    check({tag, ".drop"},  32'(drop_cnt_o),   32'(v.e_drop));
    check({tag, ".err"},   32'(err_cnt_o),    32'(v.e_err));
    check({tag, ".ovf"},   32'(overflow_o),   32'(v.e_ovf));
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input vec_t v);
    evt_valid_i = v.valid;
    evt_data_i  = v.data;
    flush_i     = v.flush;
    out_ready_i = v.ready;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t zero_v;
    vec_t v;

    // Single event with consumer ready, then it is popped.
    add_vec(1, w(2,3,'h10,1), 0, 1,  1,2,3,'h0010,1, 1, 0,0,0);
    add_vec(0, '0,            0, 1,  0,0,0,0,0,      0, 0,0,0);
    // Timestamp wrap: F0, 05, 05 (equal is not a wrap).
    add_vec(1, w(1,0,'hF0,0), 0, 0,  1,1,0,'h00F0,0, 1, 0,0,0);
    add_vec(1, w(0,1,'h05,1), 0, 0,  1,1,0,'h00F0,0, 2, 0,0,0);
    add_vec(1, w(2,2,'h05,0), 0, 0,  1,1,0,'h00F0,0, 3, 0,0,0);
    add_vec(0, '0,            0, 1,  1,0,1,'h0105,1, 2, 0,0,0);
    add_vec(0, '0,            0, 1,  1,2,2,'h0105,0, 1, 0,0,0);
    add_vec(0, '0,            0, 1,  0,0,0,0,0,      0, 0,0,0);
    // Backpressure: six events, two dropped.
    add_vec(1, w(0,0,'h20,0), 0, 0,  1,0,0,'h0120,0, 1, 0,0,0);
    add_vec(1, w(1,1,'h21,1), 0, 0,  1,0,0,'h0120,0, 2, 0,0,0);
    add_vec(1, w(2,2,'h22,0), 0, 0,  1,0,0,'h0120,0, 3, 0,0,0);
    add_vec(1, w(0,3,'h23,1), 0, 0,  1,0,0,'h0120,0, 4, 0,0,0);
    add_vec(1, w(1,0,'h24,0), 0, 0,  1,0,0,'h0120,0, 4, 1,0,1);
    add_vec(1, w(2,1,'h25,1), 0, 0,  1,0,0,'h0120,0, 4, 2,0,1);
    add_vec(0, '0,            0, 1,  1,1,1,'h0121,1, 3, 2,0,1);
    add_vec(0, '0,            0, 1,  1,2,2,'h0122,0, 2, 2,0,1);
    add_vec(0, '0,            0, 1,  1,0,3,'h0123,1, 1, 2,0,1);
    add_vec(0, '0,            0, 1,  0,0,0,0,0,      0, 2,0,1);
    // Full FIFO with simultaneous push and pop.
    add_vec(1, w(0,1,'h30,0), 0, 0,  1,0,1,'h0130,0, 1, 2,0,1);
    add_vec(1, w(1,2,'h31,1), 0, 0,  1,0,1,'h0130,0, 2, 2,0,1);
    add_vec(1, w(2,3,'h32,0), 0, 0,  1,0,1,'h0130,0, 3, 2,0,1);
    add_vec(1, w(0,0,'h33,1), 0, 0,  1,0,1,'h0130,0, 4, 2,0,1);
    add_vec(1, w(1,3,'h34,1), 0, 1,  1,1,2,'h0131,1, 4, 2,0,1);
    add_vec(0, '0,            0, 1,  1,2,3,'h0132,0, 3, 2,0,1);
    add_vec(0, '0,            0, 1,  1,0,0,'h0133,1, 2, 2,0,1);
    add_vec(0, '0,            0, 1,  1,1,3,'h0134,1, 1, 2,0,1);
    add_vec(0, '0,            0, 1,  0,0,0,0,0,      0, 2,0,1);
    // Out-of-range x (wraps the epoch anyway), then flush with 2 buffered.
    add_vec(1, w(3,1,'h02,0), 0, 0,  0,0,0,0,0,      0, 2,1,1);
    add_vec(1, w(1,1,'h03,1), 0, 0,  1,1,1,'h0203,1, 1, 2,1,1);
    add_vec(1, w(2,0,'h04,0), 0, 0,  1,1,1,'h0203,1, 2, 2,1,1);
    add_vec(1, w(0,0,'h05,0), 1, 0,  0,0,0,0,0,      0, 2,1,1);
    // Push on empty with ready high: no pop yet.
    add_vec(1, w(2,1,'h06,1), 0, 1,  1,2,1,'h0206,1, 1, 2,1,1);
    add_vec(0, '0,            0, 1,  0,0,0,0,0,      0, 2,1,1);

    zero_v = mk_vec(0, '0, 0, 0, 0,0,0,0,0, 0, 0,0,0);

    evt_valid_i = 1'b0;
    evt_data_i  = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    reset_i     = 1'b1;
    #12;
    checkOutput("reset", zero_v);
    reset_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset while three entries are buffered mid-drain.
    for (int i = 0; i < 3; i++) begin
      v = mk_vec(1, w(i, i, 'h40 + i, 1), 0, 0, 1,0,0,'h0240,1, i+1, 2,1,1);
      applyStimulus(v);
      checkOutput($sformatf("fill%0d", i), v);
    end
    out_ready_i = 1'b1;
    evt_valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("async_reset", zero_v);
    #2;
    reset_i = 1'b0;
    // Epoch and last_ts restart from zero after reset.
    v = mk_vec(1, w(1,2,'h01,0), 0, 0, 1,1,2,'h0001,0, 1, 0,0,0);
    applyStimulus(v);
    checkOutput("post_reset", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aer_event_decoder.md
Name: aer_event_decoder

Overview:
Receive side of the address-event link driven by the row/column arbiter. Each cycle it may receive one packed AER word {row address, column address, timestamp, polarity}. It range-checks the word and extends the wrapping timestamp with an epoch counter. Valid events are buffered in a FIFO and presented to the downstream consumer (frame accumulator or host bridge) over a valid/ready handshake. Dropped and malformed events are counted.

Parameters:
ROWS, 4, number of pixel rows; valid x range 0..ROWS-1
COLS, 4, number of pixel columns; valid y range 0..COLS-1
X_WIDTH, 2, row address width
Y_WIDTH, 2, column address width
TS_WIDTH, 8, raw timestamp width from the time-to-digital counter
WIDTH, X_WIDTH+Y_WIDTH+TS_WIDTH+1, packed event word width
FIFO_DEPTH, 4, event buffer depth; power of two, at least 2
EPOCH_WIDTH, 8, timestamp extension (wrap epoch) width
CNT_WIDTH, 16, drop and error counter width

Ports:
clk_i  input  1  clock
reset_i  input  1  reset
evt_valid_i  input  1  evt_data_i holds an event this cycle; no backpressure to the sender
evt_data_i  input  WIDTH  packed word: [WIDTH-1 -: X_WIDTH]=x, next Y_WIDTH bits=y, next TS_WIDTH bits=ts, [0]=polarity
flush_i  input  1  synchronous FIFO clear
out_valid_o  output  1  head event available
out_ready_i  input  1  consumer accepts the head event
out_x_o  output  X_WIDTH  row address
out_y_o  output  Y_WIDTH  column address
out_ts_o  output  EPOCH_WIDTH+TS_WIDTH  extended timestamp {epoch, ts}
out_pol_o  output  1  polarity
fifo_level_o  output  clog2(FIFO_DEPTH)+1  current occupancy
drop_cnt_o  output  CNT_WIDTH  events lost because the FIFO was full
err_cnt_o  output  CNT_WIDTH  events rejected because x>=ROWS or y>=COLS
overflow_o  output  1  sticky; set on the first drop

Behaviour:
- Reset reset_i: asynchronous, active-high; clock clk_i, rising edge.
- Reset values: FIFO empty, out_valid_o=0, out_* data=0, fifo_level_o=0, drop_cnt_o=0, err_cnt_o=0, overflow_o=0, epoch=0, last_ts=0. A reset mid-stream discards all buffered events.
- Decode is combinational on evt_data_i. All other logic is registered.
- Timestamp unwrap runs on every evt_valid_i word, including dropped and malformed ones, so time stays coherent:
  - if ts < last_ts, epoch increments modulo 2^EPOCH_WIDTH;
  - last_ts is then updated to ts;
  - ts == last_ts is not a wrap.
  - The stored extended timestamp uses the updated epoch.
- Accept rules, evaluated on evt_valid_i in priority order:
  - (1) x>=ROWS or y>=COLS: not written; err_cnt_o increments.
  - (2) FIFO full and no pop this cycle: not written; drop_cnt_o increments; overflow_o set.
  - (3) otherwise the event is written.
- A simultaneous push and pop on a full FIFO is allowed: the write succeeds and the level is unchanged.
- Counters saturate at all-ones. overflow_o clears only on reset.
- FIFO is show-ahead:
  - out_valid_o = level != 0;
  - out_x_o, out_y_o, out_ts_o and out_pol_o reflect the head entry;
  - out_* outputs read as 0 when the FIFO is empty.
- Pop occurs when out_valid_o && out_ready_i.
- Latency: a word accepted at rising edge N appears at the outputs after edge N, provided the FIFO was empty.
- Order is strict FIFO. Read and write pointers wrap modulo FIFO_DEPTH.
- Output stability: while out_valid_o=1 and out_ready_i=0, all out_* outputs hold stable.
- flush_i:
  - empties the FIFO and clears the level on the next edge;
  - an event arriving in the same cycle is discarded and not counted;
  - counters, epoch, last_ts and overflow_o are preserved.
- Push on empty with a simultaneous out_ready_i: there is no pop, because out_valid_o was 0.
- Control is the FIFO level/pointer logic. There is no stall path upstream; loss is reported only through drop_cnt_o.

Test Plan:
- Single event 0x1621 (x=2, y=3, ts=0x10, pol=1) with out_ready_i=1 -> next cycle out_valid_o=1, x=2, y=3, out_ts_o=0x0010, pol=1; one cycle later out_valid_o=0.
- Timestamp wrap: ts=0xF0, then 0x05, then 0x05 -> out_ts_o sequence 0x00F0, 0x0105, 0x0105.
- Backpressure with out_ready_i=0 and 6 valid events -> fifo_level_o=4, drop_cnt_o=2, overflow_o=1. Then out_ready_i=1 -> the first 4 events drain in order.
- Full FIFO with simultaneous push and pop -> level stays 4, no drop, and the new event is the last one out.
- Out-of-range word: ROWS=3 with x=3 -> err_cnt_o=1, no write, epoch still tracks its ts. flush_i with 2 entries buffered -> out_valid_o=0 next cycle, counters unchanged.
- Assert reset_i asynchronously mid-drain with 3 entries buffered -> all outputs return to reset values immediately, without waiting for a clock edge.
